l2_mshr_alloc: RTL and testbench
================================

// Module: l2_mshr_alloc
// PURPOSE
//  MSHR allocator for the L2 request path. Tracks valid/set of each MSHR entry and hands out the lowest free index.
//  Detects set conflicts against in-flight entries and drives l2_regs triggers: add_mshr_entry, incr_mshr_cnt, mshr_i,
//  set_set_conflict, clr_set_conflict. Sits between the L2 input arbiter (upstream) and l2_regs/MSHR storage (downstream).
// PARAMETERS
//  N_MSHR     `N_MSHR (8)     number of MSHR entries
//  MSHR_BITS  `MSHR_BITS (3)  index width, clog2(N_MSHR)
//  SET_BITS   `L2_SET_BITS (9) L2 set index width
// PORTS
//  clk               in   1          clock
//  rst               in   1          synchronous active-low reset
//  req_valid         in   1          request wants an MSHR
//  req_ready         out  1          allocation accepted this cycle
//  req_set           in   SET_BITS   set of the request; stable while req_valid && !req_ready
//  rel_valid         in   1          release one MSHR entry
//  rel_i             in   MSHR_BITS  entry to release
//  add_mshr_entry    out  1          to l2_regs: net allocation this cycle
//  incr_mshr_cnt     out  1          to l2_regs: net release this cycle
//  mshr_i            out  MSHR_BITS  index granted (valid when req_valid && req_ready)
//  set_set_conflict  out  1          to l2_regs: pulse on entering conflict wait
//  clr_set_conflict  out  1          to l2_regs: pulse on leaving conflict wait
//  mshr_full         out  1          all entries valid
//  rel_err           out  1          sticky: release of an already-free entry
// BEHAVIOUR
//  - State: vld[N_MSHR], set_q[N_MSHR][SET_BITS], FSM {IDLE, CONFL}, cnf_set reg.
//  - Reset (rst==0 at posedge): vld=0, FSM=IDLE, rel_err=0. All outputs are 0 while in reset.
//    Any in-flight request or conflict wait is dropped.
//  - hit = |(vld[k] && set_q[k]==req_set). free = ~vld; mshr_i = lowest k with free[k] (0 if none).
//  - req_ready = req_valid && !mshr_full && !hit. Purely combinational; 0-cycle latency.
//  - On fire (req_valid && req_ready): vld[mshr_i] <= 1 and set_q[mshr_i] <= req_set at the next edge.
//  - Release: if rel_valid && vld[rel_i], vld[rel_i] <= 0 at the next edge.
//    If rel_valid && !vld[rel_i], the release is ignored and rel_err <= 1 (sticky until reset).
//  - Simultaneous fire and valid release: allocation uses pre-release vld.
//    A just-released entry is not reusable until the next cycle.
//    add_mshr_entry = fire && !rel_ok; incr_mshr_cnt = rel_ok && !fire.
//    Both are 0 when both events occur, so the external count stays consistent (l2_regs prioritises add).
//  - FSM IDLE: req_valid && hit -> CONFL. set_set_conflict=1 for that cycle; cnf_set <= req_set.
//  - FSM CONFL: hit is evaluated against cnf_set.
//    When a release removes the last matching entry, clr_set_conflict=1 and -> IDLE at the next edge.
//    The request retries on the following cycle. req_ready=0 throughout CONFL.
//    A dropped req_valid in CONFL also clears (clr pulse, -> IDLE).
//  - Full (no hit): req_ready=0, no conflict pulses; accept on the first cycle with a free entry.
//  - set_set_conflict and clr_set_conflict are never asserted in the same cycle.
//  - Index arithmetic is modulo N_MSHR; the free count never wraps: add only when !full, incr only when vld.
// CONFIGURATION
//  L2_MSHR_OCC_STATS_EN defined: adds output occ_hwm [MSHR_BITS:0], the peak number of valid entries.
//    occ_hwm resets to 0 and updates one cycle after the occupancy change.
//  Undefined: no port, no logic. All other behaviour is identical.
// TESTING
//  1. Reset, then 8 requests with distinct sets on consecutive cycles -> mshr_i=0..7, add pulses x8, mshr_full=1.
//     A 9th request -> req_ready=0, no conflict pulse.
//  2. Full; release entry 5 -> incr_mshr_cnt=1.
//     A waiting request is granted next cycle with mshr_i=5.
//  3. Entry 2 holds set 0x1A; request set 0x1A -> set_set_conflict pulse, CONFL.
//     Release 2 -> clr_set_conflict pulse; request granted 2 cycles after the release with mshr_i=2.
//  4. Same cycle: fire (mshr_i=3) and release of entry 0 -> add_mshr_entry=0, incr_mshr_cnt=0.
//     vld[3]=1 and vld[0]=0 next cycle.
//  5. Release of a free entry 6 -> vld unchanged, no incr pulse, rel_err=1 and held.
//  6. rst low in CONFL with 4 valid entries -> next cycle all outputs 0, vld=0.
//     After rst high, the first request gets mshr_i=0.

Source files
------------

// File: rtl/l2_mshr_alloc.sv
// L2 MSHR allocator: lowest-free index grant, set-conflict wait, l2_regs triggers.
// Optional L2_MSHR_OCC_STATS_EN adds occ_hwm (peak valid-entry count).
module l2_mshr_alloc #(
    parameter int N_MSHR    = 8,
    parameter int MSHR_BITS = 3,
    parameter int SET_BITS  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SET_BITS-1:0]  req_set,
    input  logic                 rel_valid,
    input  logic [MSHR_BITS-1:0] rel_i,
    output logic                 add_mshr_entry,
    output logic                 incr_mshr_cnt,
    output logic [MSHR_BITS-1:0] mshr_i,
    output logic                 set_set_conflict,
    output logic                 clr_set_conflict,
    output logic                 mshr_full,
`ifdef L2_MSHR_OCC_STATS_EN
    output logic [MSHR_BITS:0]   occ_hwm,
`endif
    output logic                 rel_err
);

    typedef enum logic {IDLE, CONFL} state_t;

    state_t               r_state;
    logic [N_MSHR-1:0]    r_vld;
    logic [SET_BITS-1:0]  r_set_q [N_MSHR];
    logic [SET_BITS-1:0]  r_cnf_set;
    logic                 r_rel_err;

    logic [SET_BITS-1:0]  w_cmp_set;
    logic                 w_hit;
    logic [MSHR_BITS-1:0] w_idx;
    logic                 w_full;
    logic                 w_rel_ok;
    logic                 w_rel_bad;
    logic                 w_fire;
    logic                 w_set_p;
    logic                 w_clr_p;

    // While waiting, the conflict is tracked against the captured set.
    always_comb begin
        w_cmp_set = (r_state == CONFL) ? r_cnf_set : req_set;
        w_hit     = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N_MSHR; k++) begin
            if (r_vld[k] && r_set_q[k] == w_cmp_set) w_hit = 1'b1;
        end
        for (int k = N_MSHR - 1; k >= 0; k--) begin
            if (!r_vld[k]) w_idx = MSHR_BITS'(k);
        end
    end

    assign w_full    = &r_vld;
    assign w_rel_ok  = rst && rel_valid && r_vld[rel_i];
    assign w_rel_bad = rst && rel_valid && !r_vld[rel_i];
    assign w_fire    = rst && req_valid && !w_full && !w_hit
                       && (r_state == IDLE);
    assign w_set_p   = rst && (r_state == IDLE) && req_valid && w_hit;
    assign w_clr_p   = rst && (r_state == CONFL) && (!req_valid || !w_hit);

    assign req_ready        = w_fire;
    assign add_mshr_entry   = w_fire && !w_rel_ok;
    assign incr_mshr_cnt    = w_rel_ok && !w_fire;
    assign mshr_i           = rst ? w_idx : '0;
    assign set_set_conflict = w_set_p;
    assign clr_set_conflict = w_clr_p;
    assign mshr_full        = rst && w_full;
    assign rel_err          = rst && r_rel_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld     <= '0;
            r_state   <= IDLE;
            r_cnf_set <= '0;
            r_rel_err <= 1'b0;
        end else begin
            // Grant index is free and release index is valid: never equal.
            if (w_rel_ok) r_vld[rel_i] <= 1'b0;
            if (w_fire) r_vld[w_idx] <= 1'b1;
            if (w_rel_bad) r_rel_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_set_p) begin
                        r_state   <= CONFL;
                        r_cnf_set <= req_set;
                    end
                end
                CONFL: begin
                    if (w_clr_p) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) r_set_q[w_idx] <= req_set;
    end

`ifdef L2_MSHR_OCC_STATS_EN
    logic [MSHR_BITS:0] r_hwm;
    logic [MSHR_BITS:0] w_occ;

    assign w_occ   = (MSHR_BITS+1)'($countones(r_vld));
    assign occ_hwm = rst ? r_hwm : '0;

    always_ff @(posedge clk) begin
        if (!rst) r_hwm <= '0;
        else if (w_occ > r_hwm) r_hwm <= w_occ;
    end
`endif

endmodule

// File: tb/tb_l2_mshr_alloc.sv
// Scoreboard bench for l2_mshr_alloc: directed scenarios then random traffic
// against a per-cycle reference model of the allocation rules.
module tb_l2_mshr_alloc;

    localparam int N  = 8;
    localparam int MB = 3;
    localparam int SB = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [SB-1:0] req_set;
    logic          rel_valid;
    logic [MB-1:0] rel_i;
    logic          add_mshr_entry;
    logic          incr_mshr_cnt;
    logic [MB-1:0] mshr_i;
    logic          set_set_conflict;
    logic          clr_set_conflict;
    logic          mshr_full;
    logic          rel_err;
    logic [MB:0]   occ_hwm;

    l2_mshr_alloc dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_set(req_set),
        .rel_valid(rel_valid),
        .rel_i(rel_i),
        .add_mshr_entry(add_mshr_entry),
        .incr_mshr_cnt(incr_mshr_cnt),
        .mshr_i(mshr_i),
        .set_set_conflict(set_set_conflict),
        .clr_set_conflict(clr_set_conflict),
        .mshr_full(mshr_full),
`ifdef L2_MSHR_OCC_STATS_EN
        .occ_hwm(occ_hwm),
`endif
        .rel_err(rel_err)
    );

`ifndef L2_MSHR_OCC_STATS_EN
    assign occ_hwm = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic          ready;
        logic          add;
        logic          incr;
        logic [MB-1:0] idx;
        logic          setc;
        logic          clrc;
        logic          full;
        logic          err;
        logic [MB:0]   hwm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    bit          m_vld [N];
    logic [SB-1:0] m_set [N];
    bit          m_wait;
    logic [SB-1:0] m_wset;
    bit          m_err;
    int          m_hwm;
    bit          last_hold;
    logic [SB-1:0] last_set;

    task automatic step(input bit r, input bit rv, input logic [SB-1:0] s,
                        input bit lv, input logic [MB-1:0] li);
        exp_t e;
        int occ, match, lo;
        bit relok, fire;
        logic [SB-1:0] key;
        @(posedge clk);
        #1;
        rst = r; req_valid = rv; req_set = s; rel_valid = lv; rel_i = li;
        e = '{default: '0};
        occ = 0; match = 0; lo = -1;
        key = m_wait ? m_wset : s;
        for (int i = 0; i < N; i++) begin
            if (m_vld[i]) occ++;
            else if (lo < 0) lo = i;
            if (m_vld[i] && m_set[i] == key) match++;
        end
        if (!r) begin
            exp_q.push_back(e);
            for (int i = 0; i < N; i++) m_vld[i] = 0;
            m_wait = 0; m_err = 0; m_hwm = 0;
            last_hold = 0;
            return;
        end
        relok   = lv && m_vld[li];
        fire    = !m_wait && rv && occ < N && match == 0;
        e.ready = fire;
        e.add   = fire && !relok;
        e.incr  = relok && !fire;
        e.idx   = (lo < 0) ? '0 : MB'(lo);
        e.setc  = !m_wait && rv && match > 0;
        e.clrc  = m_wait && (!rv || match == 0);
        e.full  = (occ == N);
        e.err   = m_err;
        e.hwm   = (MB+1)'(m_hwm);
        exp_q.push_back(e);
        if (occ > m_hwm) m_hwm = occ;
        if (relok) m_vld[li] = 0;
        if (lv && !relok) m_err = 1;
        if (fire) begin
            m_vld[lo] = 1;
            m_set[lo] = s;
        end
        if (e.setc) begin
            m_wait = 1;
            m_wset = s;
        end
        if (e.clrc) m_wait = 0;
        last_hold = rv && !fire;
        last_set  = s;
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (req_ready === e.ready) && (add_mshr_entry === e.add)
                 && (incr_mshr_cnt === e.incr)
                 && (set_set_conflict === e.setc)
                 && (clr_set_conflict === e.clrc)
                 && (mshr_full === e.full) && (rel_err === e.err)
                 && (!e.ready || mshr_i === e.idx);
`ifdef L2_MSHR_OCC_STATS_EN
            ok = ok && (occ_hwm === e.hwm);
`endif
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL outs t=%0t got rdy=%b add=%b inc=%b idx=%0d set=%b clr=%b full=%b err=%b hwm=%0d exp rdy=%b add=%b inc=%b idx=%0d set=%b clr=%b full=%b err=%b hwm=%0d",
                         $time, req_ready, add_mshr_entry, incr_mshr_cnt,
                         mshr_i, set_set_conflict, clr_set_conflict,
                         mshr_full, rel_err, occ_hwm, e.ready, e.add,
                         e.incr, e.idx, e.setc, e.clrc, e.full, e.err,
                         e.hwm);
            end
        end
    end

    initial begin
        bit rv, lv;
        logic [SB-1:0] s;
        rst = 0; req_valid = 0; req_set = '0; rel_valid = 0; rel_i = '0;
        m_wait = 0; m_err = 0; m_hwm = 0; m_wset = '0;
        last_hold = 0; last_set = '0;
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 0;
            m_set[i] = '0;
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 9'h1, 1, 3);
        // Fill all entries; entry 2 gets set 0x1A
        for (int i = 0; i < N; i++) step(1, 1, SB'(9'h18 + i), 0, 0);
        step(1, 1, 9'h20, 0, 0);
        step(1, 1, 9'h20, 1, 5);
        step(1, 1, 9'h20, 0, 0);
        // Conflict on set 0x1A, released via entry 2
        step(1, 1, 9'h1A, 0, 0);
        step(1, 1, 9'h1A, 0, 0);
        step(1, 1, 9'h1A, 1, 2);
        step(1, 1, 9'h1A, 0, 0);
        step(1, 1, 9'h1A, 0, 0);
        // Fire into 3 while releasing 0
        step(1, 0, 0, 1, 3);
        step(1, 1, 9'h33, 1, 0);
        step(1, 1, 9'h34, 0, 0);
        // Bad release of a free entry
        step(1, 0, 0, 1, 6);
        step(1, 0, 0, 1, 6);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Reset during conflict wait with 4 entries valid
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, SB'(i + 1), 0, 0);
        step(1, 1, 9'h2, 0, 0);
        step(1, 1, 9'h2, 0, 0);
        step(0, 1, 9'h2, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 9'h2, 0, 0);
        // Random traffic with small set range to provoke conflicts
        for (int c = 0; c < 3000; c++) begin
            if (last_hold && $urandom_range(0, 9) != 0) begin
                rv = 1;
                s  = last_set;
            end else begin
                rv = 1'($urandom_range(0, 1));
                s  = SB'($urandom_range(0, 11));
            end
            lv = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 199) != 0), rv, s, lv,
                 MB'($urandom_range(0, N - 1)));
        end
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
